// File: rtl/fma_array_if.sv
// Shared operand/result handshake bundle for fma_array: one beat carries
// every lane's a|b|c, and the result side carries every lane's accumulator.
interface fma_array_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic [LANES*3*WIDTH-1:0] abc_in;
  logic                     valid_in;
  logic                     ready_out;
  logic                     c_load_in;
  logic                     output_can_be_valid_in;
  logic                     clear_in;
  logic [LANES*WIDTH-1:0]   out;
  logic                     valid_out;
  logic                     ready_in;
  logic [LANES-1:0]         overflow_out;

  modport master (
    output abc_in, valid_in, c_load_in, output_can_be_valid_in, clear_in, ready_in,
    input  ready_out, out, valid_out, overflow_out
  );

  modport slave (
    input  abc_in, valid_in, c_load_in, output_can_be_valid_in, clear_in, ready_in,
    output ready_out, out, valid_out, overflow_out
  );
endinterface

// File: rtl/fma_array.sv
// Multi-lane signed fixed-point fused multiply-add with per-lane accumulator,
// saturation, sticky overflow and a two-stage ready/valid pipeline.
module fma_array #(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 10,
  parameter int LANES       = 4,
  parameter int SATURATE    = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  fma_array_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

  function automatic logic sum_ovf_fn(input logic signed [SW-1:0] sum);
    return (sum > SAT_MAX) || (sum < SAT_MIN);
  endfunction

  function automatic logic [WIDTH-1:0] fit_fn(input logic signed [SW-1:0] sum);
    logic [WIDTH-1:0] r;
    if ((SATURATE != 32'sd0) && (sum > SAT_MAX)) begin
      r = SAT_MAX[WIDTH-1:0];
    end else if ((SATURATE != 32'sd0) && (sum < SAT_MIN)) begin
      r = SAT_MIN[WIDTH-1:0];
    end else begin
      r = sum[WIDTH-1:0];
    end
    return r;
  endfunction

  logic advance_s;
  logic update_s;
  logic s1_valid_r;
  logic s1_visible_r;
  logic s1_c_load_r;
  logic valid_out_r;

  assign advance_s     = !valid_out_r || bus.ready_in;
  assign update_s      = advance_s && s1_valid_r;
  assign bus.ready_out = advance_s;
  assign bus.valid_out = valid_out_r;

  // Lane-shared pipeline control: stage-1 beat flags and the output valid.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_r   <= 1'b0;
      s1_visible_r <= 1'b0;
      s1_c_load_r  <= 1'b0;
      valid_out_r  <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r   <= bus.valid_in;
      s1_visible_r <= bus.output_can_be_valid_in;
      s1_c_load_r  <= bus.c_load_in;
      valid_out_r  <= s1_valid_r && s1_visible_r;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic        [WIDTH-1:0] a_s;
    logic        [WIDTH-1:0] b_s;
    logic        [WIDTH-1:0] c_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [PW-1:0]    shifted_s;
    logic        [WIDTH-1:0] addend_s;
    logic signed [SW-1:0]    sum_s;
    logic                    sum_ovf_s;
    logic        [WIDTH-1:0] res_s;
    logic signed [PW-1:0]    s1_prod_r;
    logic        [WIDTH-1:0] s1_c_r;
    logic        [WIDTH-1:0] acc_r;
    logic                    ovf_r;

    assign a_s = bus.abc_in[g*3*WIDTH + 2*WIDTH +: WIDTH];
    assign b_s = bus.abc_in[g*3*WIDTH + WIDTH +: WIDTH];
    assign c_s = bus.abc_in[g*3*WIDTH +: WIDTH];

    // Stage-1 product and stage-2 sum; the accumulator feeds back directly so
    // consecutive accumulate beats need no forwarding.
    always_comb begin
      prod_s    = $signed({{WIDTH{a_s[WIDTH-1]}}, a_s}) * $signed({{WIDTH{b_s[WIDTH-1]}}, b_s});
      shifted_s = s1_prod_r >>> FIXED_POINT;
      if (s1_c_load_r) begin
        addend_s = s1_c_r;
      end else if (bus.clear_in) begin
        addend_s = {WIDTH{1'b0}};
      end else begin
        addend_s = acc_r;
      end
      sum_s     = $signed({shifted_s[PW-1], shifted_s})
                + $signed({{(WIDTH + 1){addend_s[WIDTH-1]}}, addend_s});
      sum_ovf_s = sum_ovf_fn(sum_s);
      res_s     = fit_fn(sum_s);
    end

    // Per-lane stage-1 operands, accumulator and sticky overflow flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        s1_prod_r <= {PW{1'b0}};
        s1_c_r    <= {WIDTH{1'b0}};
        acc_r     <= {WIDTH{1'b0}};
        ovf_r     <= 1'b0;
      end else begin
        if (advance_s) begin
          s1_prod_r <= prod_s;
          s1_c_r    <= c_s;
        end
        if (update_s) begin
          acc_r <= res_s;
          ovf_r <= (bus.clear_in ? 1'b0 : ovf_r) | sum_ovf_s;
        end else if (bus.clear_in) begin
          // A held output beat keeps its data; only the flags clear.
          ovf_r <= 1'b0;
          if (advance_s) begin
            acc_r <= {WIDTH{1'b0}};
          end
        end
      end
    end

    assign bus.out[g*WIDTH +: WIDTH] = acc_r;
    assign bus.overflow_out[g]       = ovf_r;
  end
endmodule

// File: tb/tb_fma_array.sv
// Scoreboard bench for fma_array: integer reference model predicts each visible
// beat at acceptance, a negedge monitor compares whatever the DUT delivers.
module tb_fma_array;
  localparam int WIDTH = 16;
  localparam int FP    = 10;
  localparam int LANES = 4;
  localparam int SAT   = 1;
  localparam int BW    = LANES * WIDTH;
  localparam int AW    = LANES * 3 * WIDTH;

  typedef struct {
    logic [BW-1:0]    out;
    logic [LANES-1:0] ovf;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  fma_array_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  fma_array #(.WIDTH(WIDTH), .FIXED_POINT(FP), .LANES(LANES), .SATURATE(SAT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  exp_t   exp_q[$];
  longint macc[LANES];
  bit     mflag[LANES];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     rdy_mode = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic longint sx(input logic [WIDTH-1:0] v);
    longint r;
    r = longint'(v);
    if (v[WIDTH-1]) r = r - (longint'(1) << WIDTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      macc[i]  = 0;
      mflag[i] = 1'b0;
    end
  endtask

  // Reference: out = sat(floor(a*b / 2^FP) + addend), evaluated in 64-bit integers.
  task automatic model_beat(input logic [AW-1:0] abc, input bit cl, input bit vis, input bit clr);
    exp_t        e;
    longint      hi, lo, a, b, c, p, sum;
    logic [63:0] tv;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    if (clr) model_reset();
    for (int i = 0; i < LANES; i++) begin
      a   = sx(abc[i*3*WIDTH + 2*WIDTH +: WIDTH]);
      b   = sx(abc[i*3*WIDTH + WIDTH +: WIDTH]);
      c   = sx(abc[i*3*WIDTH +: WIDTH]);
      p   = (a * b) >>> FP;
      sum = p + (cl ? c : macc[i]);
      if (sum > hi || sum < lo) begin
        mflag[i] = 1'b1;
        if (SAT != 0) begin
          macc[i] = (sum > hi) ? hi : lo;
        end else begin
          tv      = sum;
          macc[i] = sx(tv[WIDTH-1:0]);
        end
      end else begin
        macc[i] = sum;
      end
      tv = macc[i];
      e.out[i*WIDTH +: WIDTH] = tv[WIDTH-1:0];
      e.ovf[i] = mflag[i];
    end
    if (vis) exp_q.push_back(e);
  endtask

  function automatic logic [AW-1:0] rand_abc();
    logic [AW-1:0] v;
    for (int k = 0; k < LANES * 3; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [AW-1:0] lane0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    logic [AW-1:0] v;
    v = rand_abc();
    v[2*WIDTH +: WIDTH] = a;
    v[WIDTH +: WIDTH]   = b;
    v[0 +: WIDTH]       = c;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic drive(input logic [AW-1:0] abc, input bit cl, input bit vis, input bit clr);
    int waitc;
    waitc = 0;
    bus.abc_in                 = abc;
    bus.c_load_in              = cl;
    bus.output_can_be_valid_in = vis;
    bus.valid_in               = 1'b1;
    while (1) begin
      @(negedge clk_in);
      if (bus.ready_out) break;
      waitc++;
      if (waitc > 200) begin
        check("accept_timeout", 1'b0, 1'b1);
        bus.valid_in = 1'b0;
        return;
      end
      @(posedge clk_in); #1;
    end
    model_beat(abc, cl, vis, clr);
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Downstream readiness: random, forced high, or forced low.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      if (rdy_mode == 0) bus.ready_in = ($urandom_range(0, 9) < 7);
      else bus.ready_in = (rdy_mode == 1);
    end
  end

  // Monitor: compare each delivered beat with the scoreboard head.
  initial begin
    logic          hold;
    logic [BW-1:0] held;
    exp_t          e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        check("ready_out", bus.ready_out, !bus.valid_out || bus.ready_in);
        if (hold) check("hold_out", {bus.valid_out, bus.out}, {1'b1, held});
        if (bus.valid_out && bus.ready_in) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("out", bus.out, e.out);
            check("overflow", bus.overflow_out, e.ovf);
          end
        end
        hold = bus.valid_out && !bus.ready_in;
        held = bus.out;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int w;
    bus.abc_in = '0;
    bus.valid_in = 1'b0;
    bus.c_load_in = 1'b0;
    bus.output_can_be_valid_in = 1'b0;
    bus.clear_in = 1'b0;
    bus.ready_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_out", bus.out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_ovf", bus.overflow_out, 0);
    check("rst_ready", bus.ready_out, 1);
    #3 rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Basic Q5.10 beat and latency.
    drive(lane0(16'h0800, 16'h0600, 16'h0100), 1'b1, 1'b1, 1'b0);
    bus.valid_in = 1'b0;
    check("latency_s1", bus.valid_out, 0);
    @(posedge clk_in); #1;
    check("latency_out", bus.valid_out, 1);
    @(posedge clk_in); #1;
    check("single_pulse", bus.valid_out, 0);

    // Sign handling and truncation toward -inf, back to back.
    drive(lane0(16'hFC00, 16'h0200, 16'h0000), 1'b1, 1'b1, 1'b0);
    drive(lane0(16'hFFFF, 16'h0001, 16'h0000), 1'b1, 1'b1, 1'b0);
    drive(lane0(16'h0001, 16'h0001, 16'h0000), 1'b1, 1'b1, 1'b0);

    // Saturation with sticky flag, then idle clear.
    drive(lane0(16'h7FFF, 16'h7FFF, 16'h0000), 1'b1, 1'b1, 1'b0);
    drive(lane0(16'h0800, 16'h0600, 16'h0100), 1'b1, 1'b1, 1'b0);
    drive(lane0(16'h8000, 16'h7FFF, 16'h0000), 1'b1, 1'b1, 1'b0);
    idle(3);
    bus.clear_in = 1'b1;
    @(posedge clk_in); #1;
    bus.clear_in = 1'b0;
    model_reset();
    check("clear_out", bus.out, 0);
    check("clear_ovf", bus.overflow_out, 0);
    drive(lane0(16'h0800, 16'h0600, 16'h0100), 1'b1, 1'b1, 1'b0);

    // Accumulate chain: one visible beat at the end.
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b1, 1'b0, 1'b0);
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b0, 1'b0, 1'b0);
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b0, 1'b0, 1'b0);
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b0, 1'b1, 1'b0);

    // clear_in coincident with an accumulate beat in stage 2.
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b0, 1'b1, 1'b1);
    bus.valid_in = 1'b0;
    bus.clear_in = 1'b1;
    @(posedge clk_in); #1;
    bus.clear_in = 1'b0;
    idle(2);

    // Backpressure: 6 beats with ready_in low 3 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 6; k++) drive(rand_abc(), 1'($urandom), 1'b1, 1'b0);
        bus.valid_in = 1'b0;
      end
      begin
        repeat (3) @(posedge clk_in);
        rdy_mode = 2;
        repeat (3) @(posedge clk_in);
        rdy_mode = 1;
      end
    join
    idle(4);

    // Asynchronous reset between edges with beats in flight.
    drive(rand_abc(), 1'b1, 1'b1, 1'b0);
    drive(rand_abc(), 1'b1, 1'b1, 1'b0);
    bus.valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_out", bus.out, 0);
    check("async_rst_valid", bus.valid_out, 0);
    check("async_rst_ovf", bus.overflow_out, 0);
    check("async_rst_ready", bus.ready_out, 1);
    exp_q.delete();
    model_reset();
    @(posedge clk_in);
    #4 rst_in = 1'b0;
    @(posedge clk_in); #1;
    idle(2);
    check("no_stale_valid", bus.valid_out, 0);
    drive(lane0(16'h0400, 16'h0400, 16'h0000), 1'b0, 1'b1, 1'b0);

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int k = 0; k < 300; k++) begin
      drive(rand_abc(), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    bus.valid_in = 1'b0;
    rdy_mode = 1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk_in); #1;
      w++;
    end
    check("drain", exp_q.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
